// File: rtl/convolution_2d_handshake_tx_pkg.sv
// Shared types and helpers for the two-phase handshake transmitter.
// FSM encodings live here so every unit agrees on them.
package convolution_2d_handshake_tx_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } tx_state_e;

    function automatic int cnt_width(input int t);
        int w;
        w = (t > 0) ? $clog2(t + 1) : 1;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/convolution_2d_sync.sv
// Multi-flop synchronizer for a single-bit level crossing into clk.
// ACTIVE_HIGH=0 presents the synchronized level inverted.
module convolution_2d_sync #(
    parameter int ACTIVE_HIGH = 1,
    parameter int CYCLES      = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [CYCLES:0] sr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i <= CYCLES; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = (ACTIVE_HIGH != 0) ? sr[CYCLES] : ~sr[CYCLES];

endmodule

// File: rtl/convolution_2d_handshake_tx.sv
// Two-phase request/ack transmitter: bundles one word per toggle of tx_req
// and waits for the synchronized ack to match before taking the next word.
module convolution_2d_handshake_tx
    import convolution_2d_handshake_tx_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int CYCLES  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic             reset_n,
    input  logic             clk,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             tx_req,
    output logic [WIDTH-1:0] tx_data,
    input  logic             rx_ack,
    output logic             done,
    output logic             err_timeout,
    output logic             err_protocol
);

    localparam int            CW    = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT);
    localparam bit            TO_EN = (TIMEOUT != 0);

    tx_state_e     state_q;
    tx_state_e     state_d;
    logic          ack_s;
    logic          accept;
    logic          ack_hit;
    logic [CW-1:0] cnt_q;

    convolution_2d_sync #(
        .ACTIVE_HIGH(1),
        .CYCLES     (CYCLES)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (rx_ack),
        .q      (ack_s)
    );

    assign in_ready = (state_q == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ack_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_s == tx_req) begin
                    ack_hit = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_req  <= 1'b0;
            tx_data <= '0;
            done    <= 1'b0;
        end else begin
            done <= ack_hit;
            if (accept) begin
                tx_req  <= ~tx_req;
                tx_data <= in_data;
            end
        end
    end

    // Counter saturates so a very late ack cannot wrap it back below TIMEOUT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == WAIT_ACK && cnt_q != TMAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_timeout  <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            if (TO_EN && state_q == WAIT_ACK && cnt_q != TMAX
                && (cnt_q + 1'b1) == TMAX) begin
                err_timeout <= 1'b1;
            end
            if (state_q == IDLE && ack_s != tx_req) begin
                err_protocol <= 1'b1;
            end
        end
    end

endmodule
